// File: rtl/vproc_vreg_wr_arbiter.sv
// Vector register file write-port arbiter: grants up to PORT_WR_CNT requesters per cycle, with no two grants to the same address.
// Define VPROC_WR_ARB_RR_EN for round-robin priority; otherwise scanning always starts at requester 0.
module vproc_vreg_wr_arbiter #(
    parameter int REQ_CNT     = 4,
    parameter int PORT_WR_CNT = 2,
    parameter int MAX_PORT_W  = 128,
    parameter int ADDR_W      = 5
) (
    input  logic                                     clk_i,
    input  logic                                     sync_rst_i,
    input  logic                                     hold_i,
    input  logic [REQ_CNT-1:0]                       req_valid_i,
    output logic [REQ_CNT-1:0]                       req_ready_o,
    input  logic [REQ_CNT*ADDR_W-1:0]                req_addr_i,
    input  logic [REQ_CNT*MAX_PORT_W-1:0]            req_data_i,
    input  logic [REQ_CNT*(MAX_PORT_W/8)-1:0]        req_be_i,
    output logic [PORT_WR_CNT-1:0]                   wr_we_o,
    output logic [PORT_WR_CNT*ADDR_W-1:0]            wr_addr_o,
    output logic [PORT_WR_CNT*MAX_PORT_W-1:0]        wr_data_o,
    output logic [PORT_WR_CNT*(MAX_PORT_W/8)-1:0]    wr_be_o,
    output logic [PORT_WR_CNT*$clog2(REQ_CNT)-1:0]   wr_src_o
);

    localparam int BE_W  = MAX_PORT_W / 8;
    localparam int SRC_W = $clog2(REQ_CNT);

    logic [REQ_CNT-1:0]                grant;
    logic [PORT_WR_CNT-1:0]            nxt_we;
    logic [PORT_WR_CNT*ADDR_W-1:0]     nxt_addr;
    logic [PORT_WR_CNT*MAX_PORT_W-1:0] nxt_data;
    logic [PORT_WR_CNT*BE_W-1:0]       nxt_be;
    logic [PORT_WR_CNT*SRC_W-1:0]      nxt_src;
    logic [SRC_W-1:0]                  sel;
    logic [ADDR_W-1:0]                 cur_addr;
    logic                              conflict;
    int unsigned                       start_idx;
    int unsigned                       idx;
    int unsigned                       grant_cnt;

`ifdef VPROC_WR_ARB_RR_EN
    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] last_idx;
    assign start_idx = 32'(rr_ptr);
`else
    assign start_idx = 0;
`endif

    // Scan from start_idx; each grant takes the next free port and reserves its address.
    always_comb begin
        grant     = '0;
        nxt_we    = '0;
        nxt_addr  = '0;
        nxt_data  = '0;
        nxt_be    = '0;
        nxt_src   = '0;
        sel       = '0;
        cur_addr  = '0;
        conflict  = 1'b0;
        idx       = 0;
        grant_cnt = 0;
`ifdef VPROC_WR_ARB_RR_EN
        last_idx  = '0;
`endif
        for (int unsigned k = 0; k < REQ_CNT; k++) begin
            idx = start_idx + k;
            if (idx >= REQ_CNT) begin
                idx = idx - REQ_CNT;
            end
            sel      = SRC_W'(idx);
            cur_addr = req_addr_i[idx*ADDR_W +: ADDR_W];
            conflict = 1'b0;
            for (int unsigned p = 0; p < PORT_WR_CNT; p++) begin
                if (p < grant_cnt && nxt_addr[p*ADDR_W +: ADDR_W] == cur_addr) begin
                    conflict = 1'b1;
                end
            end
            if (req_valid_i[sel] && !hold_i && !sync_rst_i &&
                grant_cnt < PORT_WR_CNT && !conflict) begin
                grant[sel] = 1'b1;
                for (int unsigned p = 0; p < PORT_WR_CNT; p++) begin
                    if (p == grant_cnt) begin
                        nxt_we[p]                         = 1'b1;
                        nxt_addr[p*ADDR_W +: ADDR_W]      = cur_addr;
                        nxt_data[p*MAX_PORT_W +: MAX_PORT_W] = req_data_i[idx*MAX_PORT_W +: MAX_PORT_W];
                        nxt_be[p*BE_W +: BE_W]            = req_be_i[idx*BE_W +: BE_W];
                        nxt_src[p*SRC_W +: SRC_W]         = sel;
                    end
                end
`ifdef VPROC_WR_ARB_RR_EN
                last_idx = sel;
`endif
                grant_cnt = grant_cnt + 1;
            end
        end
    end

    assign req_ready_o = grant;

`ifdef VPROC_WR_ARB_RR_EN
    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            rr_ptr <= '0;
        end else if (|grant) begin
            rr_ptr <= (last_idx == SRC_W'(REQ_CNT - 1)) ? '0 : last_idx + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            wr_we_o   <= '0;
            wr_addr_o <= '0;
            wr_data_o <= '0;
            wr_be_o   <= '0;
            wr_src_o  <= '0;
        end else begin
            wr_we_o   <= nxt_we;
            wr_addr_o <= nxt_addr;
            wr_data_o <= nxt_data;
            wr_be_o   <= nxt_be;
            wr_src_o  <= nxt_src;
        end
    end

endmodule

// File: doc/vproc_vreg_wr_arbiter.md
# vproc_vreg_wr_arbiter

Write-port arbiter for the vector register file. It shares the register file's PORT_WR_CNT write ports between REQ_CNT functional-unit write requesters using valid/ready handshakes and round-robin priority. It blocks same-cycle writes to the same register, because the XOR-composed multi-port RAM behind it does not define them. Grant outputs are registered, so write ports are driven one cycle after a handshake.

## Interface
- REQ_CNT, 4: number of write requesters (2..8)
- PORT_WR_CNT, 2: number of register file write ports (1..REQ_CNT)
- MAX_PORT_W, 128: write data width in bits (multiple of 8)
- ADDR_W, 5: vector register address width
- clk_i  in  1  clock
- sync_rst_i  in  1  synchronous reset, active-high
- hold_i  in  1  when high, no grants are issued this cycle
- req_valid_i  in  REQ_CNT  requester has a write pending
- req_ready_o  out  REQ_CNT  requester granted this cycle (combinational)
- req_addr_i  in  REQ_CNT x ADDR_W  target register per requester
- req_data_i  in  REQ_CNT x MAX_PORT_W  write data per requester
- req_be_i  in  REQ_CNT x MAX_PORT_W/8  byte enables per requester
- wr_we_o  out  PORT_WR_CNT  write-port enable (registered)
- wr_addr_o  out  PORT_WR_CNT x ADDR_W  write-port address (registered)
- wr_data_o  out  PORT_WR_CNT x MAX_PORT_W  write-port data (registered)
- wr_be_o  out  PORT_WR_CNT x MAX_PORT_W/8  write-port byte enables (registered)
- wr_src_o  out  PORT_WR_CNT x clog2(REQ_CNT)  index of the requester owning each port (registered)

## Operation
- **Scan order:** requesters are scanned in priority order starting at rr_ptr, wrapping modulo REQ_CNT.
- **Grant rule:** a requester is granted when all of the following hold:
  - req_valid_i is high;
  - hold_i is low;
  - fewer than PORT_WR_CNT grants have already been made this cycle;
  - its req_addr_i differs from the address of every requester already granted this cycle.
- **Port assignment:** the k-th grant in scan order goes to port k. Unused ports get wr_we_o=0.
- **Handshake:** req_ready_o[i] is high only for granted requesters. A transfer happens when valid and ready are both high.
- **Requester obligation:** a requester whose valid is high and ready is low keeps addr, data and be stable.
- **Valid without ready:** req_ready_o may assert while req_valid_i is low? No. Ready is never high without valid.
- **rr_ptr update:** after a cycle with at least one grant, rr_ptr = (index of the last requester granted + 1) mod REQ_CNT. With no grants, rr_ptr is unchanged.
- **Zero byte enables:** a request with all-zero req_be_i is still granted and consumes a port, with wr_we_o=1 and be=0.
- **Reset:** rr_ptr=0. All wr_* outputs are 0. req_ready_o is 0 while sync_rst_i is high, whatever the inputs.
- **Reset mid-operation:** writes already registered are dropped (wr_we_o forced to 0 on the next edge). There is no partial-transfer state.

## Timing
- Grant is combinational from req_valid_i, req_addr_i, hold_i and rr_ptr.
- A handshake in cycle N appears on wr_* in cycle N+1 and is held for exactly one cycle.
- Throughput is up to PORT_WR_CNT writes per cycle, with no bubbles between consecutive grants.
- Only same-cycle address conflicts are checked. Writes to the same register in cycles N and N+1 are legal.
- Fairness: a continuously valid, non-conflicting requester is granted within ceil(REQ_CNT/PORT_WR_CNT) cycles in which hold_i is low.

## Configuration
- **VPROC_WR_ARB_RR_EN defined:** round-robin priority with rr_ptr as described above.
- **VPROC_WR_ARB_RR_EN undefined:** fixed priority. Scanning always starts at requester 0, and the rr_ptr register is removed.
- Address-conflict blocking, latency and port assignment are identical in both builds.

## Test plan
- **Reset:** hold sync_rst_i with all req_valid_i=1 → req_ready_o=0, wr_we_o=0. First grant after reset goes to requester 0.
- **Port allocation:** REQ_CNT=4, PORT_WR_CNT=2, requesters 0–3 valid with addresses 1,2,3,4 → cycle 0 grants {0,1} to ports {0,1}. Cycle 1 (RR) grants {2,3}. wr_addr_o shows 1,2 then 3,4, each one cycle later.
- **Address conflict:** requesters 0 and 1 both target address 7 → only 0 is granted, and requester 2 takes port 1. Requester 1 is granted next cycle, and wr_addr_o=7 appears in two consecutive cycles.
- **Hold:** hold_i=1 for 3 cycles with all requesters valid → no ready, wr_we_o=0, rr_ptr unchanged. Grants resume on the cycle hold_i falls.
- **Mid-stream reset:** reset asserted for 1 cycle with a registered write pending → wr_we_o=0 next cycle and rr_ptr=0.
- **Fixed priority (RR build disabled):** requester 0 continuously valid, PORT_WR_CNT=1 → requester 3 is never granted (expected starvation).
